// File: rtl/fifo_read_streamer.sv
// Read-side consumer for an async FIFO: issues reads ahead into a 3-entry skid
// buffer and re-presents the words as a valid/ready stream, with a drain-and-discard flush.
module fifo_read_streamer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_r_clk,
  input  logic             i_rreset,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_re,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_flushing,
  output logic [CNT_W-1:0] o_rd_count,
  output logic [CNT_W-1:0] o_drop_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_buf [0:2];
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] r_drop_count;

  logic [2:0]       w_level;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_wptr_nxt;
  logic [1:0]       w_rptr_nxt;

  // A word already requested still needs a slot, so it counts against the buffer.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign o_re       = !i_rreset & !i_empty & ((r_state == ST_FLUSH) | (w_level < 3'd3));
  assign o_valid    = !i_rreset & (r_state == ST_RUN) & (r_occ != 2'd0);
  assign o_data     = i_rreset ? '0 : r_buf[r_rptr];
  assign o_flushing = !i_rreset & (r_state == ST_FLUSH);
  assign o_rd_count   = r_rd_count;
  assign o_drop_count = r_drop_count;

  assign w_push     = r_inflight;
  assign w_pop      = o_valid & i_ready;
  assign w_wptr_nxt = (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
  assign w_rptr_nxt = (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;

  always_ff @(posedge i_r_clk) begin
    if (i_rreset) begin
      r_state      <= ST_RUN;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_inflight   <= 1'b0;
      r_rd_count   <= '0;
      r_drop_count <= '0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= o_re;
      if (r_state == ST_RUN) begin
        if (i_flush) begin
          // Everything buffered plus the word landing this edge is discarded.
          r_state      <= ST_FLUSH;
          r_occ        <= '0;
          r_wptr       <= '0;
          r_rptr       <= '0;
          r_drop_count <= r_drop_count + CNT_W'(r_occ) + CNT_W'(r_inflight);
        end else begin
          if (w_push) begin
            r_buf[r_wptr] <= i_rdata;
            r_wptr        <= w_wptr_nxt;
          end
          if (w_pop) begin
            r_rptr     <= w_rptr_nxt;
            r_rd_count <= r_rd_count + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_occ <= r_occ + 2'd1;
          end else if (!w_push && w_pop) begin
            r_occ <= r_occ - 2'd1;
          end
        end
      end else begin
        if (r_inflight) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
        if (!i_flush && i_empty && !r_inflight) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a queue-based FIFO and stream model checked every cycle,
// plus directed scenarios with literal expectations. A second instance uses 4-bit counters.
module tb_fifo_read_streamer;

  logic       clock = 1'b0;
  logic       reset;
  logic       fifoEmpty;
  logic [7:0] fifoRdata;
  logic       ready;
  logic       flush;

  logic        reA, validA, flushingA;
  logic [7:0]  dataA;
  logic [15:0] rdCntA, dropCntA;
  logic        reB, validB, flushingB;
  logic [7:0]  dataB;
  logic [3:0]  rdCntB, dropCntB;

  always #5 clock = ~clock;

  fifo_read_streamer #(.WIDTH(8), .CNT_W(16)) dutA (
    .i_r_clk(clock), .i_rreset(reset), .i_empty(fifoEmpty), .i_rdata(fifoRdata),
    .o_re(reA), .o_valid(validA), .o_data(dataA), .i_ready(ready), .i_flush(flush),
    .o_flushing(flushingA), .o_rd_count(rdCntA), .o_drop_count(dropCntA)
  );

  fifo_read_streamer #(.WIDTH(8), .CNT_W(4)) dutB (
    .i_r_clk(clock), .i_rreset(reset), .i_empty(fifoEmpty), .i_rdata(fifoRdata),
    .o_re(reB), .o_valid(validB), .o_data(dataB), .i_ready(ready), .i_flush(flush),
    .o_flushing(flushingB), .o_rd_count(rdCntB), .o_drop_count(dropCntB)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  fifoQ [$];
  logic [7:0]  mBuf [$];
  bit          mFlush = 1'b0;
  bit          mInfl = 1'b0;
  logic [31:0] mRd = '0;
  logic [31:0] mDrop = '0;

  logic [7:0] delivered [$];
  logic [7:0] sent [$];
  int cycleNum = 0;
  int firstRe = -1;
  int firstValid = -1;
  int rePulses = 0;
  int guard;
  bit sawFlushing;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNum);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit rdy);
    reset = r;
    flush = f;
    ready = rdy;
  endtask

  task automatic pushWord(input logic [7:0] w);
    fifoQ.push_back(w);
    sent.push_back(w);
    fifoEmpty = 1'b0;
  endtask

  // Expected outputs follow from the words the model holds, not from any register encoding.
  task automatic checkOutput(output bit expRe);
    bit expValid;
    expRe    = !reset && fifoQ.size() != 0 && (mFlush || (mBuf.size() + int'(mInfl)) < 3);
    expValid = !reset && !mFlush && mBuf.size() > 0;
    check("o_re", 32'(reA), 32'(expRe));
    check("o_re_b", 32'(reB), 32'(expRe));
    check("o_valid", 32'(validA), 32'(expValid));
    check("o_valid_b", 32'(validB), 32'(expValid));
    check("o_flushing", 32'(flushingA), 32'(!reset && mFlush));
    check("o_flushing_b", 32'(flushingB), 32'(!reset && mFlush));
    if (reset) begin
      check("o_data_rst", 32'(dataA), 32'h0);
    end else if (expValid) begin
      check("o_data", 32'(dataA), 32'(mBuf[0]));
      check("o_data_b", 32'(dataB), 32'(mBuf[0]));
    end
    check("rd_count", 32'(rdCntA), 32'(mRd[15:0]));
    check("rd_count_b", 32'(rdCntB), 32'(mRd[3:0]));
    check("drop_count", 32'(dropCntA), 32'(mDrop[15:0]));
    check("drop_count_b", 32'(dropCntB), 32'(mDrop[3:0]));
  endtask

  task automatic cycle();
    bit expRe, sReset, sFlush, sReady, sReA, sEmpty;
    logic [7:0] sRdata;
    @(negedge clock);
    checkOutput(expRe);
    sReset = reset; sFlush = flush; sReady = ready; sReA = reA;
    sEmpty = fifoEmpty; sRdata = fifoRdata;
    if (reA && firstRe < 0) firstRe = cycleNum;
    if (validA && firstValid < 0) firstValid = cycleNum;
    if (reA) rePulses++;
    if (validA && ready) delivered.push_back(dataA);
    @(posedge clock);
    #1;
    if (sReset) begin
      mBuf.delete();
      mFlush = 1'b0;
      mInfl  = 1'b0;
      mRd    = '0;
      mDrop  = '0;
    end else begin
      if (!mFlush) begin
        if (sFlush) begin
          mDrop = mDrop + 32'(mBuf.size()) + 32'(mInfl);
          mBuf.delete();
          mFlush = 1'b1;
        end else begin
          if (mBuf.size() > 0 && sReady) begin
            void'(mBuf.pop_front());
            mRd = mRd + 1;
          end
          if (mInfl) mBuf.push_back(sRdata);
        end
      end else begin
        if (mInfl) mDrop = mDrop + 1;
        if (!sFlush && sEmpty && !mInfl) mFlush = 1'b0;
      end
      mInfl = expRe;
    end
    if (sReA && fifoQ.size() > 0) fifoRdata = fifoQ.pop_front();
    fifoEmpty = (fifoQ.size() == 0);
    cycleNum++;
  endtask

  initial begin
    fifoRdata = '0;
    fifoEmpty = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) cycle();

    // T1: 16 words at full throughput
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) pushWord(8'(i));
    firstRe = -1; firstValid = -1; delivered.delete();
    repeat (22) cycle();
    check("T1 latency", 32'(firstValid - firstRe), 32'd2);
    check("T1 count", 32'(delivered.size()), 32'd16);
    check("T1 word5", 32'(delivered[5]), 32'h5);
    check("T1 word15", 32'(delivered[15]), 32'hF);
    check("T1 rd_count", 32'(rdCntA), 32'd16);
    check("T1 rd_count_b", 32'(rdCntB), 32'd0);
    check("T1 re idle", 32'(reA), 32'd0);

    // T2: backpressure then release
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) pushWord(8'(100 + i));
    rePulses = 0; delivered.delete();
    repeat (8) cycle();
    check("T2 re pulses", 32'(rePulses), 32'd3);
    check("T2 valid held", 32'(validA), 32'd1);
    check("T2 data held", 32'(dataA), 32'd100);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (16) cycle();
    check("T2 count", 32'(delivered.size()), 32'd10);
    check("T2 last", 32'(delivered[9]), 32'd109);
    check("T2 rd_count", 32'(rdCntA), 32'd26);

    // T3: alternating ready with random data
    sent.delete(); delivered.delete();
    for (int i = 0; i < 32; i++) pushWord(8'($urandom_range(0, 255)));
    for (int i = 0; i < 90; i++) begin
      applyStimulus(1'b0, 1'b0, (i % 2) == 0);
      cycle();
    end
    check("T3 count", 32'(delivered.size()), 32'd32);
    check("T3 first", 32'(delivered[0]), 32'(sent[0]));
    check("T3 last", 32'(delivered[31]), 32'(sent[31]));
    check("T3 rd_count", 32'(rdCntA), 32'd58);
    check("T3 rd_count_b", 32'(rdCntB), 32'd10);

    // T4: deliver 4 of 20, then flush the rest
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) pushWord(8'(8'h40 + i));
    delivered.delete();
    guard = 0;
    while (delivered.size() < 4 && guard < 50) begin
      cycle();
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("T4 flushing", 32'(flushingA), 32'd1);
    check("T4 valid off", 32'(validA), 32'd0);
    sawFlushing = 1'b1;
    guard = 0;
    while (flushingA && guard < 40) begin
      cycle();
      guard++;
    end
    check("T4 back to run", 32'(flushingA), 32'd0);
    check("T4 delivered", 32'(delivered.size()), 32'd4);
    check("T4 drop_count", 32'(dropCntA), 32'd16);
    check("T4 drop_count_b", 32'(dropCntB), 32'd0);
    check("T4 rd_count", 32'(rdCntA), 32'd62);
    check("T4 fifo drained", 32'(fifoEmpty), 32'(sawFlushing));

    // T5: reset with two buffered words and one in flight
    for (int i = 0; i < 10; i++) pushWord(8'(8'h80 + i));
    repeat (3) cycle();
    check("T5 valid before", 32'(validA), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cycle();
    check("T5 valid rst", 32'(validA), 32'd0);
    check("T5 re rst", 32'(reA), 32'd0);
    check("T5 rd_count rst", 32'(rdCntA), 32'd0);
    check("T5 drop_count rst", 32'(dropCntA), 32'd0);
    fifoQ.delete();
    fifoEmpty = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    delivered.delete();
    for (int i = 0; i < 5; i++) pushWord(8'(200 + i));
    repeat (10) cycle();
    check("T5 first", 32'(delivered[0]), 32'd200);
    check("T5 count", 32'(delivered.size()), 32'd5);
    check("T5 rd_count", 32'(rdCntA), 32'd5);

    // T6: 17 words wrap the 4-bit counter to 1
    applyStimulus(1'b1, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) pushWord(8'(i * 3));
    repeat (25) cycle();
    check("T6 rd_count_b wrap", 32'(rdCntB), 32'd1);
    check("T6 rd_count", 32'(rdCntA), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
